alu8x8_ctrl: RTL and testbench

//  Command sequencer directly upstream of the 8x8 ALU (alu8x8_p).
//  - Accepts ALU commands {a, b, cin, op} over a valid/ready handshake.
//  - Drives them as registered operands into the combinational ALU.
//  - Waits a fixed settle time, then captures the 16-bit result.
//  - Returns the result over a valid/ready response handshake.
//  - Isolates the ALU from bus timing; gives the datapath a clean
//    one-command-at-a-time interface.

---
 rtl/alu8x8_ctrl.sv | 112 +++++++++++
 tb/tb_alu8x8_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu8x8_ctrl.sv
// Command sequencer in front of the combinational 8x8 ALU: registers one command
// into the ALU, waits a fixed settle time, captures the result and hands it back.
module alu8x8_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_cin,
  input  logic [2:0]       cmd_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic [15:0]      alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_res,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] done_cnt
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu8x8_ctrl: SETTLE_CYCLES=%0d outside legal range 1..15", SETTLE_CYCLES);
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t           r_state;
  logic [3:0]       r_settle;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic             r_alu_cin;
  logic [2:0]       r_alu_op;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_res;
  logic             r_rsp_zero;
  logic [CNT_W-1:0] r_done_cnt;
  logic             w_res_zero;

  assign w_res_zero = (alu_res == 16'h0000);

  // NOTE: every register here, data included, is cleared by the async reset so an
  // aborted command leaves no stale operands or result visible on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_settle    <= 4'd0;
      r_alu_a     <= 8'd0;
      r_alu_b     <= 8'd0;
      r_alu_cin   <= 1'b0;
      r_alu_op    <= 3'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= 16'd0;
      r_rsp_zero  <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every branch reading pre-edge state.
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_alu_a   <= cmd_a;
            r_alu_b   <= cmd_b;
            r_alu_cin <= cmd_cin;
            r_alu_op  <= cmd_op;
            r_settle  <= SETTLE_LD;
            r_state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_settle <= r_settle - 4'd1;
          if (r_settle == 4'd1) begin
            r_rsp_res   <= alu_res;
            r_rsp_zero  <= w_res_zero;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // A command waiting here is only taken after we are back in IDLE.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + CNT_W'(1);
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_cin   = r_alu_cin;
  assign alu_op    = r_alu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_res   = r_rsp_res;
  assign rsp_zero  = r_rsp_zero;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_alu8x8_ctrl.sv
// Bench for alu8x8_ctrl: two instances (SETTLE=1/CNT_W=4 and SETTLE=4/CNT_W=16)
// checked every cycle against a cycle-stamped transaction model plus literal values.
module tb_alu8x8_ctrl;

  localparam int S_CFG [2] = '{1, 4};
  localparam logic [15:0] CNT_MASK [2] = '{16'h000F, 16'hFFFF};

  logic clk = 1'b0;
  logic rst;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [7:0]  cmd_a     [2];
  logic [7:0]  cmd_b     [2];
  logic        cmd_cin   [2];
  logic [2:0]  cmd_op    [2];
  logic [7:0]  alu_a     [2];
  logic [7:0]  alu_b     [2];
  logic        alu_cin   [2];
  logic [2:0]  alu_op    [2];
  logic [15:0] alu_res   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_res   [2];
  logic        rsp_zero  [2];
  logic [15:0] done      [2];
  logic [3:0]  done_w;
  logic [15:0] done_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic [2:0] op);
    case (op)
      3'd0:    return 16'(a) + 16'(b) + 16'(cin);
      3'd1:    return 16'(a) - 16'(b);
      3'd2:    return 16'(a & b);
      3'd3:    return 16'(a) * 16'(b);
      3'd4:    return 16'(a | b);
      default: return 16'(a ^ b);
    endcase
  endfunction

  assign alu_res[0] = alu_f(alu_a[0], alu_b[0], alu_cin[0], alu_op[0]);
  assign alu_res[1] = alu_f(alu_a[1], alu_b[1], alu_cin[1], alu_op[1]);
  assign done[0]    = {12'h000, done_w};
  assign done[1]    = done_n;

  alu8x8_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_cin(cmd_cin[0]), .cmd_op(cmd_op[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_cin(alu_cin[0]), .alu_op(alu_op[0]),
    .alu_res(alu_res[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_res(rsp_res[0]), .rsp_zero(rsp_zero[0]), .done_cnt(done_w)
  );

  alu8x8_ctrl #(.SETTLE_CYCLES(4), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_cin(cmd_cin[1]), .cmd_op(cmd_op[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_cin(alu_cin[1]), .alu_op(alu_op[1]),
    .alu_res(alu_res[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_res(rsp_res[1]), .rsp_zero(rsp_zero[1]), .done_cnt(done_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: a command is in flight from its accept edge; its result
  // appears S edges later and stays until a handshake edge retires it.
  longint      cyc;
  logic        m_busy [2];
  logic        m_rsp  [2];
  longint      m_acc  [2];
  logic [7:0]  m_a    [2];
  logic [7:0]  m_b    [2];
  logic        m_cin  [2];
  logic [2:0]  m_op   [2];
  logic [15:0] m_res  [2];
  logic        m_zero [2];
  logic [15:0] m_done [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_rsp[i] <= 1'b0; m_acc[i] <= 0;
        m_a[i] <= 8'd0; m_b[i] <= 8'd0; m_cin[i] <= 1'b0; m_op[i] <= 3'd0;
        m_res[i] <= 16'd0; m_zero[i] <= 1'b0; m_done[i] <= 16'd0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (m_rsp[i]) begin
          if (rsp_ready[i]) begin
            m_busy[i] <= 1'b0;
            m_rsp[i]  <= 1'b0;
            m_done[i] <= (m_done[i] + 16'd1) & CNT_MASK[i];
          end
        end else if (m_busy[i]) begin
          if (cyc - m_acc[i] == longint'(S_CFG[i])) begin
            m_rsp[i]  <= 1'b1;
            m_res[i]  <= alu_f(m_a[i], m_b[i], m_cin[i], m_op[i]);
            m_zero[i] <= (alu_f(m_a[i], m_b[i], m_cin[i], m_op[i]) == 16'd0);
          end
        end else if (cmd_valid[i]) begin
          m_busy[i] <= 1'b1;
          m_acc[i]  <= cyc;
          m_a[i]    <= cmd_a[i];
          m_b[i]    <= cmd_b[i];
          m_cin[i]  <= cmd_cin[i];
          m_op[i]   <= cmd_op[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cmp%0d.cmd_ready", i), 32'(cmd_ready[i]), 32'(!m_busy[i]));
      check($sformatf("cmp%0d.rsp_valid", i), 32'(rsp_valid[i]), 32'(m_rsp[i]));
      check($sformatf("cmp%0d.rsp_res", i),   32'(rsp_res[i]),   32'(m_res[i]));
      check($sformatf("cmp%0d.rsp_zero", i),  32'(rsp_zero[i]),  32'(m_zero[i]));
      check($sformatf("cmp%0d.done_cnt", i),  32'(done[i]),      32'(m_done[i]));
      check($sformatf("cmp%0d.alu_ops", i),
            32'({alu_a[i], alu_b[i], alu_cin[i], alu_op[i]}),
            32'({m_a[i], m_b[i], m_cin[i], m_op[i]}));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input int i, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [2:0] op);
    int t = 0;
    while (!cmd_ready[i] && t < 50) begin
      step(1);
      t++;
    end
    if (t >= 50) check("send_ready_timeout", 32'd0, 32'd1);
    cmd_a[i] = a; cmd_b[i] = b; cmd_cin[i] = cin; cmd_op[i] = op;
    cmd_valid[i] = 1'b1;
    step(1);
    cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i);
    int t = 0;
    while (!rsp_valid[i] && t < 50) begin
      step(1);
      t++;
    end
    if (t >= 50) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_rsp(input int i);
    rsp_ready[i] = 1'b1;
    step(1);
    rsp_ready[i] = 1'b0;
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_a[i] = 8'd0; cmd_b[i] = 8'd0;
      cmd_cin[i] = 1'b0; cmd_op[i] = 3'd0; rsp_ready[i] = 1'b0;
    end
    step(3);
    rst = 1'b0;
    check("post_reset.cmd_ready", 32'(cmd_ready[0]), 32'd1);
    check("post_reset.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    step(1);

    // Basic: 12*11, one settle edge.
    cmd_a[0] = 8'd12; cmd_b[0] = 8'd11; cmd_cin[0] = 1'b0; cmd_op[0] = 3'd3;
    cmd_valid[0] = 1'b1;
    step(1);
    cmd_valid[0] = 1'b0;
    check("basic.rsp_valid_early", 32'(rsp_valid[0]), 32'd0);
    check("basic.alu_a", 32'(alu_a[0]), 32'd12);
    step(1);
    check("basic.rsp_valid", 32'(rsp_valid[0]), 32'd1);
    check("basic.rsp_res", 32'(rsp_res[0]), 32'd132);
    check("basic.rsp_zero", 32'(rsp_zero[0]), 32'd0);

    // Backpressure with a competing command pending.
    cmd_a[0] = 8'd1; cmd_b[0] = 8'd2; cmd_op[0] = 3'd3; cmd_valid[0] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      check("bp.rsp_res", 32'(rsp_res[0]), 32'd132);
      check("bp.alu_a", 32'(alu_a[0]), 32'd12);
      check("bp.cmd_ready", 32'(cmd_ready[0]), 32'd0);
      step(1);
    end
    rsp_ready[0] = 1'b1;
    step(1);
    rsp_ready[0] = 1'b0;
    check("bp.rsp_valid_cleared", 32'(rsp_valid[0]), 32'd0);
    check("bp.done_cnt", 32'(done[0]), 32'd1);
    check("bp.idle", 32'(cmd_ready[0]), 32'd1);
    check("bp.cmd_not_taken", 32'(alu_a[0]), 32'd12);
    step(1);
    cmd_valid[0] = 1'b0;
    check("bp.cmd_taken", 32'(alu_a[0]), 32'd1);
    wait_rsp(0);
    check("bp.second_res", 32'(rsp_res[0]), 32'd2);
    finish_rsp(0);

    // Settle of four edges on the second instance.
    cmd_a[1] = 8'hFF; cmd_b[1] = 8'hFF; cmd_cin[1] = 1'b0; cmd_op[1] = 3'd3;
    cmd_valid[1] = 1'b1;
    step(1);
    cmd_valid[1] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("settle.rsp_valid_early", 32'(rsp_valid[1]), 32'd0);
      step(1);
    end
    check("settle.rsp_valid", 32'(rsp_valid[1]), 32'd1);
    check("settle.rsp_res", 32'(rsp_res[1]), 32'hFE01);
    finish_rsp(1);
    check("settle.done_cnt", 32'(done[1]), 32'd1);

    // Zero flag and a non-multiply opcode.
    send(0, 8'h00, 8'h55, 1'b0, 3'd3);
    wait_rsp(0);
    check("zero.rsp_res", 32'(rsp_res[0]), 32'd0);
    check("zero.rsp_zero", 32'(rsp_zero[0]), 32'd1);
    finish_rsp(0);
    send(0, 8'd200, 8'd100, 1'b1, 3'd0);
    wait_rsp(0);
    check("add.rsp_res", 32'(rsp_res[0]), 32'h012D);
    check("add.rsp_zero", 32'(rsp_zero[0]), 32'd0);
    finish_rsp(0);

    // Reset mid-run: instance 1 in SETTLE, instance 0 holding a response.
    send(1, 8'd3, 8'd5, 1'b0, 3'd3);
    send(0, 8'd7, 8'd9, 1'b0, 3'd3);
    step(1);
    check("abort.pre_rsp_valid0", 32'(rsp_valid[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.rsp_valid0", 32'(rsp_valid[0]), 32'd0);
    check("abort.rsp_res0", 32'(rsp_res[0]), 32'd0);
    check("abort.done0", 32'(done[0]), 32'd0);
    check("abort.alu_ops0", 32'({alu_a[0], alu_b[0], alu_cin[0], alu_op[0]}), 32'd0);
    check("abort.alu_ops1", 32'({alu_a[1], alu_b[1], alu_cin[1], alu_op[1]}), 32'd0);
    check("abort.done1", 32'(done[1]), 32'd0);
    step(1);
    rst = 1'b0;
    check("abort.cmd_ready0", 32'(cmd_ready[0]), 32'd1);
    check("abort.cmd_ready1", 32'(cmd_ready[1]), 32'd1);
    for (int j = 0; j < 8; j++) begin
      check("abort.no_rsp1", 32'(rsp_valid[1]), 32'd0);
      step(1);
    end
    check("abort.done1_after", 32'(done[1]), 32'd0);

    // Counter wrap on the 4-bit instance.
    for (int n = 0; n < 16; n++) begin
      send(0, 8'(n), 8'd1, 1'b0, 3'd3);
      wait_rsp(0);
      if (n == 15) check("wrap.done_before", 32'(done[0]), 32'd15);
      finish_rsp(0);
    end
    check("wrap.done_cnt", 32'(done[0]), 32'd0);
    rsp_ready[0] = 1'b1;
    step(2);
    rsp_ready[0] = 1'b0;
    check("wrap.ready_outside_resp", 32'(done[0]), 32'd0);

    step(1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
